// File: rtl/star_actuator_driver_pkg.sv
// Shared codes for the grill/star actuator driver.
// Position codes, command bit map and axis state encoding.
package star_actuator_driver_pkg;

  localparam logic [1:0] POS_HOME = 2'b00;
  localparam logic [1:0] POS_END  = 2'b01;
  localparam logic [1:0] POS_MID  = 2'b10;

  localparam int CMD_GRILL_OPEN  = 3;
  localparam int CMD_GRILL_CLOSE = 2;
  localparam int CMD_STAR_HIDE   = 1;
  localparam int CMD_STAR_EXTEND = 0;

  typedef enum logic [2:0] {
    AX_STOP     = 3'd0,
    AX_DEAD     = 3'd1,
    AX_RUN_END  = 3'd2,
    AX_RUN_HOME = 3'd3,
    AX_FAULT    = 3'd4
  } axis_state_t;

  function automatic logic [1:0] pos_code(
    input logic at_home,
    input logic at_end
  );
    unique case (1'b1)
      at_home && !at_end: pos_code = POS_HOME;
      at_end && !at_home: pos_code = POS_END;
      default:            pos_code = POS_MID;
    endcase
  endfunction

  // Motor bits are {end, home}; only a RUN state drives.
  function automatic logic [1:0] motor_of(input axis_state_t s);
    unique case (s)
      AX_RUN_END:  motor_of = 2'b10;
      AX_RUN_HOME: motor_of = 2'b01;
      default:     motor_of = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/star_actuator_driver_axis.sv
// One actuator axis: limit sync/debounce, position code,
// dead-time motor FSM with run timeout and sticky fault.
module actuator_axis
  import star_actuator_driver_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEAD_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       req_end,
  input  logic       req_home,
  input  logic       lim_home,
  input  logic       lim_end,
  output logic [1:0] pos,
  output logic [1:0] motor,
  output logic       fault
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DW  = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int RW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0]  DEAD_LOAD = DW'(DEAD_CYCLES - 1);
  localparam logic [RW-1:0]  RUN_LAST  = RW'(TIMEOUT_CYCLES - 1);

  // Index 0 is the home limit, index 1 the end limit.
  logic [1:0]     raw;
  logic [1:0]     sync1;
  logic [1:0]     sync2;
  logic [1:0]     deb;
  logic [1:0]     deb_nxt;
  logic [DBW-1:0] db_cnt [2];

  axis_state_t state, state_nxt;
  logic          dir, dir_nxt;
  logic [DW-1:0] dead_cnt, dead_nxt;
  logic [RW-1:0] run_cnt, run_nxt;

  logic valid_end;
  logic valid_home;
  logic any_req;
  logic req_lim;
  logic tgt_lim;
  logic both_lim;

  assign raw = {lim_end, lim_home};

  // Two-flop synchroniser for the raw switches.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounced value flips on the last cycle of a stable difference.
  always_comb begin
    deb_nxt = deb;
    for (int i = 0; i < 2; i++) begin
      if (sync2[i] != deb[i] && db_cnt[i] == DB_LAST)
        deb_nxt[i] = sync2[i];
    end
  end

  // Debounce counters restart whenever the input agrees again.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      deb <= 2'b00;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      deb <= deb_nxt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i] || db_cnt[i] == DB_LAST)
          db_cnt[i] <= '0;
        else
          db_cnt[i] <= db_cnt[i] + 1'b1;
      end
    end
  end

  assign valid_end  = req_end & ~req_home;
  assign valid_home = req_home & ~req_end;
  assign any_req    = valid_end | valid_home;
  assign req_lim    = valid_end ? deb[1] : deb[0];
  assign tgt_lim    = dir ? deb[1] : deb[0];
  assign both_lim   = &deb_nxt;

  // Next-state logic: every start or reversal passes through DEAD.
  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    dead_nxt  = dead_cnt;
    run_nxt   = run_cnt;
    if (both_lim) begin
      state_nxt = AX_FAULT;
    end else begin
      unique case (state)
        AX_STOP: begin
          if (any_req && !req_lim) begin
            state_nxt = AX_DEAD;
            dir_nxt   = valid_end;
            dead_nxt  = DEAD_LOAD;
          end
        end
        AX_DEAD: begin
          if (!any_req || req_lim) begin
            state_nxt = AX_STOP;
          end else if (valid_end != dir) begin
            dir_nxt  = valid_end;
            dead_nxt = DEAD_LOAD;
          end else if (dead_cnt == '0) begin
            state_nxt = dir ? AX_RUN_END : AX_RUN_HOME;
            run_nxt   = '0;
          end else begin
            dead_nxt = dead_cnt - 1'b1;
          end
        end
        AX_RUN_END, AX_RUN_HOME: begin
          if (tgt_lim || !any_req) begin
            state_nxt = AX_STOP;
          end else if (valid_end != dir) begin
            state_nxt = AX_DEAD;
            dir_nxt   = valid_end;
            dead_nxt  = DEAD_LOAD;
          end else if (run_cnt == RUN_LAST) begin
            state_nxt = AX_FAULT;
          end else begin
            run_nxt = run_cnt + 1'b1;
          end
        end
        AX_FAULT: state_nxt = AX_FAULT;
        default:  state_nxt = AX_FAULT;
      endcase
    end
  end

  // FSM state, direction and counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= AX_STOP;
      dir      <= 1'b0;
      dead_cnt <= '0;
      run_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      dir      <= dir_nxt;
      dead_cnt <= dead_nxt;
      run_cnt  <= run_nxt;
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pos   <= POS_MID;
      motor <= 2'b00;
      fault <= 1'b0;
    end else begin
      pos   <= pos_code(deb_nxt[0], deb_nxt[1]);
      motor <= motor_of(state_nxt);
      fault <= (state_nxt == AX_FAULT);
    end
  end

endmodule

// File: rtl/star_actuator_driver.sv
// Grill and star actuator driver top.
// Two identical axes; only command and limit mapping here.
module star_actuator_driver
  import star_actuator_driver_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEAD_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_cmd,
  input  logic       i_grill_lim_closed,
  input  logic       i_grill_lim_open,
  input  logic       i_star_lim_up,
  input  logic       i_star_lim_hidden,
  output logic [1:0] o_grill_pos,
  output logic [1:0] o_star_pos,
  output logic [1:0] o_grill_motor,
  output logic [1:0] o_star_motor,
  output logic       o_grill_fault,
  output logic       o_star_fault
);

  actuator_axis #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DEAD_CYCLES    (DEAD_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_grill (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .req_end (i_cmd[CMD_GRILL_OPEN]),
    .req_home(i_cmd[CMD_GRILL_CLOSE]),
    .lim_home(i_grill_lim_closed),
    .lim_end (i_grill_lim_open),
    .pos     (o_grill_pos),
    .motor   (o_grill_motor),
    .fault   (o_grill_fault)
  );

  actuator_axis #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DEAD_CYCLES    (DEAD_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_star (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .req_end (i_cmd[CMD_STAR_HIDE]),
    .req_home(i_cmd[CMD_STAR_EXTEND]),
    .lim_home(i_star_lim_up),
    .lim_end (i_star_lim_hidden),
    .pos     (o_star_pos),
    .motor   (o_star_motor),
    .fault   (o_star_fault)
  );

endmodule

// File: doc/star_actuator_driver.md
STAR_ACTUATOR_DRIVER -- requirements
Module: star_actuator_driver

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles before a limit-switch change is accepted.
REQ-002 SHALL have parameter DEAD_CYCLES, default 8: motor-off cycles before any motor start or reversal.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum run cycles before the target limit is reached.
REQ-004 SHALL have one clock and asynchronous active-high reset: i_clk input 1 (all logic on rising edge); i_rst input 1.
REQ-005 i_cmd  input  4  motor request from star state machine: [3] grill open, [2] grill close, [1] star hide, [0] star extend.
REQ-006 i_grill_lim_closed, i_grill_lim_open, i_star_lim_up, i_star_lim_hidden  input  1 each  raw asynchronous limit switches, active-high.
REQ-007 o_grill_pos  output  2  00 closed, 01 open, 10 between/moving.
REQ-008 o_star_pos  output  2  00 up, 01 hidden, 10 between/moving.
REQ-009 o_grill_motor  output  2  {open, close} drive enables.
REQ-010 o_star_motor  output  2  {hide, extend} drive enables.
REQ-011 o_grill_fault, o_star_fault  output  1 each  sticky per-axis fault.

Function
REQ-012 Each axis SHALL be independent: grill uses i_cmd[3:2]; star uses i_cmd[1:0]. Direction "end" is grill open / star hide; "home" is grill close / star extend.
REQ-013 Each limit input SHALL pass a 2-flop synchroniser, then a debouncer; the debounced value SHALL change only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-014 Position code SHALL be registered from debounced limits: home only -> 00; end only -> 01; neither -> 10; both -> 10 and axis fault set.
REQ-015 A request with both axis command bits set SHALL be treated as no request.
REQ-016 Per-axis FSM states SHALL be: STOP, DEAD, RUN_END, RUN_HOME, FAULT.
REQ-017 STOP: motor 00; a valid request whose target debounced limit is not active -> DEAD, direction latched, dead counter loaded; a request toward an already-active limit SHALL be ignored.
REQ-018 DEAD: motor 00; request dropped -> STOP; request reversed -> reload counter, latch new direction; counter expired -> RUN_END/RUN_HOME; the motor bit SHALL assert exactly DEAD_CYCLES+1 edges after the request is first sampled.
REQ-019 RUN: exactly one motor bit set; target debounced limit active -> STOP, motor cleared on the next edge; request dropped -> STOP; request reversed -> DEAD, never a direct reversal.
REQ-020 A run counter SHALL clear on RUN entry and increment each RUN cycle; on reaching TIMEOUT_CYCLES -> FAULT.
REQ-021 FAULT: motor 00, fault output 1; exit only by reset; both-limits condition SHALL force FAULT from any state.
REQ-022 Both bits of a motor output SHALL never be 1 simultaneously, in any state or cycle.
REQ-023 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-024 While i_rst is high: all FSMs STOP, counters 0, motors 00, faults 0, debounced limits 0, positions 10.
REQ-025 Reset asserted mid-run SHALL remove motor drive asynchronously; after release, positions SHALL settle by DEBOUNCE_CYCLES+3 cycles with stable switches.

Structure
REQ-026 A shared package SHALL hold the position codes (00/01/10), i_cmd bit indices and the axis state encoding.
REQ-027 One sub-module, actuator_axis (synchroniser, 2 debouncers, FSM, counters), SHALL be instantiated twice; the top contains only instantiation and port mapping.

Verification (DEBOUNCE_CYCLES=4, DEAD_CYCLES=2, TIMEOUT_CYCLES=50)
REQ-028 Grill closed, i_cmd=1000 -> o_grill_motor=10 at edge 3; drop lim_closed -> o_grill_pos=10 after 6 cycles; assert lim_open -> o_grill_pos=01 after 6 cycles, motor 00 one edge later.
REQ-029 Star running hide (01 -> 10 on motor), i_cmd 0010 -> 0001 -> motor 00 for exactly 2 cycles, then o_star_motor=01; never 11.
REQ-030 Grill running, no limit change for 50 cycles -> o_grill_fault=1, motor 00; fault held until i_rst.
REQ-031 Limit glitch of 3 cycles -> position unchanged; 4-cycle stable change -> position updates.
REQ-032 Star hidden, i_cmd=0010 -> no motor start; i_cmd=0011 -> motor stays 00.
REQ-033 Both grill limits asserted 6 cycles -> o_grill_fault=1, o_grill_pos=10; i_rst pulse mid-run -> motors 00 immediately.
